lfsr_stream_cipher: RTL and testbench

//  Hardware LFSR stream cipher engine: encrypts or decrypts a byte stream using a Fibonacci LFSR

---
 rtl/lfsr_stream_cipher.sv | 139 +++++++++++++
 tb/tb_lfsr_stream_cipher.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher engine: byte-stream encrypt/decrypt with a Fibonacci LFSR keystream and
// seed recovery from a known preamble. Optional parity protection on bit DW-1 via `PARITY_EN.
module lfsr_stream_cipher #(
    parameter int              W        = 7,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   OFFSET   = 8'h20,
    parameter logic [DW-1:0]   PRE_CHAR = 8'h20,
    parameter int              MAX_LEN  = 64,
    parameter int              CLW      = $clog2(MAX_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_load,
    input  logic           cfg_mode,
    input  logic           cfg_recover,
    input  logic [W-1:0]   cfg_taps,
    input  logic [W-1:0]   cfg_seed,
    input  logic [CLW-1:0] cfg_len,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           busy,
    output logic           done,
    output logic           seed_err,
    output logic           parity_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DW-1:0] PRE_MINUS = PRE_CHAR - OFFSET;

    state_t         state, state_next;
    logic [W-1:0]   lfsr, taps_r;
    logic           mode_r, recover_r;
    logic [CLW-1:0] len_r, count, fed;

    logic           in_acc, out_acc, last;
    logic           rec_now, rec_zero;
    logic [W-1:0]   s_cur, s_rec, lfsr_step;
    logic [DW-1:0]  data_m, s_ext, result;
`ifdef PARITY_EN
    logic           par_bad;
    logic           parity_q;
`endif

    assign busy     = (state == RUN);
    assign in_ready = (state == RUN) && (!out_valid || out_ready) && (fed < len_r);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign last     = (count == len_r - CLW'(1));
    assign done     = (state == RUN) && out_acc && last;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cfg_load) state_next = RUN;
            RUN:  if (out_acc && last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Keystream word for the current byte; recovery substitutes the seed implied by the preamble.
    always_comb begin
        data_m = in_data;
`ifdef PARITY_EN
        par_bad = mode_r && (in_data[DW-1] != ^in_data[DW-2:0]);
        if (mode_r) data_m[DW-1] = 1'b0;
`endif
        rec_now  = mode_r && recover_r && (fed == '0);
        s_rec    = data_m[W-1:0] ^ PRE_MINUS[W-1:0];
        rec_zero = rec_now && (s_rec == '0);
        s_cur    = lfsr;
        if (rec_now) s_cur = (s_rec == '0) ? W'(1) : s_rec;
        s_ext     = {{(DW-W){1'b0}}, s_cur};
        lfsr_step = {s_cur[W-2:0], ^(s_cur & taps_r)};
        if (rec_now)     result = PRE_CHAR;
        else if (mode_r) result = (data_m ^ s_ext) + OFFSET;
        else             result = (data_m - OFFSET) ^ s_ext;
`ifdef PARITY_EN
        if (!mode_r) result[DW-1] = ^result[DW-2:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= W'(1);
            taps_r    <= '0;
            mode_r    <= 1'b0;
            recover_r <= 1'b0;
            len_r     <= CLW'(1);
            count     <= '0;
            fed       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            seed_err  <= 1'b0;
        end else if (state == IDLE && cfg_load) begin
            taps_r    <= cfg_taps;
            mode_r    <= cfg_mode;
            recover_r <= cfg_recover;
            len_r     <= (cfg_len == '0) ? CLW'(1) : cfg_len;
            lfsr      <= (cfg_seed == '0) ? W'(1) : cfg_seed;
            seed_err  <= (cfg_seed == '0);
            count     <= '0;
            fed       <= '0;
        end else begin
            if (out_acc) begin
                out_valid <= 1'b0;
                count     <= count + CLW'(1);
            end
            if (in_acc) begin
                out_valid <= 1'b1;
                out_data  <= result;
                lfsr      <= lfsr_step;
                fed       <= fed + CLW'(1);
                if (rec_zero) seed_err <= 1'b1;
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         parity_q <= 1'b0;
        else if (state == IDLE && cfg_load) parity_q <= 1'b0;
        else if (in_acc && par_bad)         parity_q <= 1'b1;
    end
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Scoreboard bench for lfsr_stream_cipher: directed vectors, zero seed, recovery, random stalls, mid-run reset.
module tb_lfsr_stream_cipher;

    localparam int W   = 7;
    localparam int DW  = 8;
    localparam int CLW = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_load, cfg_mode, cfg_recover;
    logic [W-1:0]   cfg_taps, cfg_seed;
    logic [CLW-1:0] cfg_len;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]  in_data, out_data;
    logic           busy, done, seed_err, parity_err;

    int             vectors = 0;
    int             miscompares = 0;
    logic [7:0]     sb[$];
    logic [7:0]     msg_in[64];
    logic [7:0]     msg_exp[64];

    always #5 clk = ~clk;

    lfsr_stream_cipher dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_recover(cfg_recover),
        .cfg_taps(cfg_taps), .cfg_seed(cfg_seed), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .seed_err(seed_err), .parity_err(parity_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] nextState(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Drives one message and scores every output byte against constants or the reference model.
    task automatic applyStimulus(input logic mode, input logic rec, input logic [6:0] taps,
                                 input logic [6:0] seed, input int len, input bit use_exp,
                                 input bit stall, input logic exp_seed_err);
        logic [6:0] ml, s;
        logic [7:0] e, d, held;
        int len_eff, idx, outs, cyc;
        bit prev_stalled;
        ml = (seed == 0) ? 7'd1 : seed;
        len_eff = (len == 0) ? 1 : len;
        idx = 0; outs = 0; cyc = 0; prev_stalled = 0; held = 8'h00;
        sb.delete();
        @(negedge clk);
        cfg_mode = mode; cfg_recover = rec; cfg_taps = taps; cfg_seed = seed;
        cfg_len = CLW'(len); cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        checkOutput("busy_after_load", busy, 1);
        checkOutput("seed_err_after_load", seed_err, exp_seed_err);
        while (outs < len_eff && cyc < 2000) begin
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (idx < len_eff) begin
                in_valid = 1'b1;
                in_data = msg_in[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stalled) checkOutput("stall_hold_data", out_data, held);
            if (out_valid && !out_ready) checkOutput("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                if (mode && rec && idx == 0) begin
                    s = in_data[6:0];
                    if (s == 0) s = 7'd1;
                    e = 8'h20;
                    ml = nextState(s, taps);
                end else if (mode) begin
                    d = in_data;
`ifdef PARITY_EN
                    d[7] = 1'b0;
`endif
                    e = (d ^ {1'b0, ml}) + 8'h20;
                    ml = nextState(ml, taps);
                end else begin
                    e = (in_data - 8'h20) ^ {1'b0, ml};
`ifdef PARITY_EN
                    e[7] = ^e[6:0];
`endif
                    ml = nextState(ml, taps);
                end
                if (use_exp) e = msg_exp[idx];
                sb.push_back(e);
                idx++;
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                checkOutput("out_data", out_data, e);
                checkOutput("done_pulse", done, outs == len_eff - 1);
                outs++;
            end
            prev_stalled = out_valid && !out_ready;
            held = out_data;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) checkOutput("message_timeout", 1, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("busy_end", busy, 0);
        checkOutput("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_load = 0; cfg_mode = 0; cfg_recover = 0;
        cfg_taps = 0; cfg_seed = 0; cfg_len = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        #23;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_seed_err", seed_err, 0);
        checkOutput("rst_parity_err", parity_err, 0);
        checkOutput("rst_lfsr", dut.lfsr, 7'h01);
        rst_n = 1'b1;

        msg_in[0] = 8'h20; msg_in[1] = 8'h40; msg_in[2] = 8'h20;
`ifdef PARITY_EN
        msg_exp[0] = 8'h81; msg_exp[1] = 8'h22; msg_exp[2] = 8'h84;
`else
        msg_exp[0] = 8'h01; msg_exp[1] = 8'h22; msg_exp[2] = 8'h04;
`endif
        applyStimulus(1'b0, 1'b0, 7'h48, 7'h01, 3, 1, 0, 1'b0);
        // Zero seed must behave exactly like seed 1 but flag it.
        applyStimulus(1'b0, 1'b0, 7'h48, 7'h00, 3, 1, 0, 1'b1);
        checkOutput("seed_err_sticky", seed_err, 1);

        msg_in[0] = 8'h01; msg_in[1] = 8'h22;
        msg_exp[0] = 8'h20; msg_exp[1] = 8'h40;
        applyStimulus(1'b1, 1'b0, 7'h48, 7'h01, 2, 1, 0, 1'b0);
`ifdef PARITY_EN
        checkOutput("parity_err_dec", parity_err, 1);
`else
        checkOutput("parity_err_dec", parity_err, 0);
`endif

        msg_in[0] = 8'h5A; msg_in[1] = 8'h34;
        msg_exp[0] = 8'h20; msg_exp[1] = 8'h20;
        applyStimulus(1'b1, 1'b1, 7'h48, 7'h01, 2, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 7'h48, 7'h01, 1, 1, 0, 1'b0);
        checkOutput("recover_lfsr", dut.lfsr, 7'h34);

        msg_in[0] = 8'h37;
        applyStimulus(1'b0, 1'b0, 7'h48, 7'h05, 0, 0, 0, 1'b0);

        for (int i = 0; i < 64; i++) msg_in[i] = 8'($urandom);
        applyStimulus(1'b0, 1'b0, 7'h48, 7'h2B, 64, 0, 1, 1'b0);
        for (int i = 0; i < 64; i++) msg_in[i] = 8'($urandom);
        applyStimulus(1'b1, 1'b1, 7'h41, 7'h11, 64, 0, 1, 1'b0);
        for (int i = 0; i < 64; i++) msg_in[i] = 8'($urandom);
        applyStimulus(1'b1, 1'b0, 7'h60, 7'h7F, 40, 0, 1, 1'b0);

        // Abort a message with reset while output is stalled.
        @(negedge clk);
        cfg_mode = 0; cfg_recover = 0; cfg_taps = 7'h48; cfg_seed = 7'h01;
        cfg_len = CLW'(10); cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_done", done, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
